// File: rtl/el2_dccm_export_sram_pkg.sv
// rtl/el2_dccm_export_sram_pkg.sv - shared geometry, fault-injection request type and helpers for the DCCM export SRAM
package el2_dccm_export_sram_pkg;

    localparam int DCCM_NUM_BANKS    = 4;
    localparam int DCCM_BITS         = 16;
    localparam int DCCM_BANK_BITS    = 2;
    localparam int DCCM_DATA_WIDTH   = 32;
    localparam int DCCM_ECC_WIDTH    = 7;
    localparam int DCCM_FDATA_WIDTH  = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;
    // Word address bits per bank: byte address minus bank select minus byte-in-word.
    localparam int DCCM_AW           = DCCM_BITS - (DCCM_BANK_BITS + 2);
    localparam int DCCM_DEPTH        = 1 << DCCM_AW;

    // Latched one-shot fault-injection request for one bank.
    typedef struct packed {
        logic       valid;
        logic [5:0] bit_idx;
        logic       dbl;
    } el2_dccm_err_inj_t;

    // Inversion mask for a latched request; the second bit of a double
    // fault wraps from the top ECC bit back to data bit 0.
    function automatic logic [DCCM_FDATA_WIDTH-1:0] el2_dccm_inj_mask(input el2_dccm_err_inj_t req);
        logic [DCCM_FDATA_WIDTH-1:0] one;
        logic [DCCM_FDATA_WIDTH-1:0] m;
        logic [5:0]                  nxt;
        one = {{(DCCM_FDATA_WIDTH-1){1'b0}}, 1'b1};
        m   = '0;
        nxt = '0;
        if (req.valid) begin
            m = one << req.bit_idx;
            if (req.dbl) begin
                nxt = (req.bit_idx == 6'(DCCM_FDATA_WIDTH - 1)) ? 6'd0 : req.bit_idx + 6'd1;
                m   = m | (one << nxt);
            end
        end
        return m;
    endfunction

    // Only bit indices inside the stored {ecc,data} word may be armed.
    function automatic logic el2_dccm_inj_bit_ok(input logic [5:0] bit_idx);
        return bit_idx < 6'(DCCM_FDATA_WIDTH);
    endfunction

endpackage

// File: rtl/el2_dccm_export_sram_if.sv
// rtl/el2_dccm_export_sram_if.sv - exported DCCM bank bus between the core (master) and the SRAM model (slave)
// Signals: dccm_clken/dccm_wren_bank per-bank enable and write select, dccm_addr_bank word address,
// dccm_wr_data_bank/dccm_wr_ecc_bank write word, dccm_bank_dout/dccm_bank_ecc registered read word.
interface el2_dccm_export_sram_if;
    import el2_dccm_export_sram_pkg::*;

    logic [DCCM_NUM_BANKS-1:0]                      dccm_clken;
    logic [DCCM_NUM_BANKS-1:0]                      dccm_wren_bank;
    logic [DCCM_NUM_BANKS-1:0][DCCM_AW-1:0]         dccm_addr_bank;
    logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_wr_data_bank;
    logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_wr_ecc_bank;
    logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_bank_dout;
    logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_bank_ecc;

    modport master (
        output dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
        input  dccm_bank_dout, dccm_bank_ecc
    );

    modport slave (
        input  dccm_clken, dccm_wren_bank, dccm_addr_bank, dccm_wr_data_bank, dccm_wr_ecc_bank,
        output dccm_bank_dout, dccm_bank_ecc
    );

endinterface

// File: rtl/el2_dccm_export_bank.sv
// rtl/el2_dccm_export_bank.sv - one DCCM bank: {ecc,data} array, registered read port, optional one-shot fault injection
// Ports: clk, rst_l (async active-low); clken_i/wren_i/addr_i/wr_data_i/wr_ecc_i access request;
// dout_o/ecc_o registered read word. With EL2_DCCM_ERR_INJ_EN: inj_arm_i/inj_bit_i/inj_dbl_i
// arm a request (already range-checked by the top), pending_o shows an armed request.
module el2_dccm_export_bank
    import el2_dccm_export_sram_pkg::*;
#(
    parameter int AW = DCCM_AW,
    parameter int DW = DCCM_DATA_WIDTH,
    parameter int EW = DCCM_ECC_WIDTH
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          clken_i,
    input  logic          wren_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [EW-1:0] wr_ecc_i,
    output logic [DW-1:0] dout_o,
    output logic [EW-1:0] ecc_o
`ifdef EL2_DCCM_ERR_INJ_EN
    ,
    input  logic          inj_arm_i,
    input  logic [5:0]    inj_bit_i,
    input  logic          inj_dbl_i,
    output logic          pending_o
`endif
);

    localparam int FW    = DW + EW;
    localparam int DEPTH = 1 << AW;

    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] rd_q;
    logic [FW-1:0] rd_d;
    logic [FW-1:0] flip;
    logic          rd_en;
    logic          wr_en;

    assign rd_en = clken_i & ~wren_i;
    assign wr_en = clken_i &  wren_i;

    // Array is deliberately not reset. Gating with rst_l drops a write
    // sampled on the same edge that reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en && rst_l) begin
            mem_q[addr_i] <= {wr_ecc_i, wr_data_i};
        end
    end

`ifdef EL2_DCCM_ERR_INJ_EN
    el2_dccm_err_inj_t req_q;
    el2_dccm_err_inj_t req_d;

    // An armed request is consumed by the next read whose edge does not
    // itself re-arm; a same-edge arm leaves the read clean and the (new)
    // request pending. Corruption is applied only on the output path.
    always_comb begin
        req_d = req_q;
        flip  = '0;
        if (rd_en && req_q.valid && !inj_arm_i) begin
            flip        = el2_dccm_inj_mask(req_q);
            req_d.valid = 1'b0;
        end
        if (inj_arm_i) begin
            req_d.valid   = 1'b1;
            req_d.bit_idx = inj_bit_i;
            req_d.dbl     = inj_dbl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign pending_o = req_q.valid;
`else
    assign flip = '0;
`endif

    // Output register only loads on a read; it holds across idle and write cycles.
    assign rd_d = rd_en ? (mem_q[addr_i] ^ flip) : rd_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign dout_o = rd_q[DW-1:0];
    assign ecc_o  = rd_q[FW-1:DW];

endmodule

// File: rtl/el2_dccm_export_sram.sv
// rtl/el2_dccm_export_sram.sv - banked single-port SRAM responder for the exported DCCM interface
// Ports: clk (exported mem clock), rst_l (async active-low), dccm (slave modport of
// el2_dccm_export_sram_if). Optional macro EL2_DCCM_ERR_INJ_EN adds err_inj_valid, err_inj_bank,
// err_inj_bit, err_inj_double inputs and err_inj_pending output for one-shot read fault injection.
// ECC is stored and returned verbatim; it is never generated or checked here.
module el2_dccm_export_sram
    import el2_dccm_export_sram_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_l,
    el2_dccm_export_sram_if.slave       dccm
`ifdef EL2_DCCM_ERR_INJ_EN
    ,
    input  logic                        err_inj_valid,
    input  logic [DCCM_BANK_BITS-1:0]   err_inj_bank,
    input  logic [5:0]                  err_inj_bit,
    input  logic                        err_inj_double,
    output logic [DCCM_NUM_BANKS-1:0]   err_inj_pending
`endif
);

    logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] bank_dout;
    logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  bank_ecc;

`ifdef EL2_DCCM_ERR_INJ_EN
    logic [DCCM_NUM_BANKS-1:0] inj_arm;
`endif

    for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_bank
`ifdef EL2_DCCM_ERR_INJ_EN
        // Out-of-range bit indices never arm anything.
        assign inj_arm[b] = err_inj_valid
                          && (err_inj_bank == DCCM_BANK_BITS'(b))
                          && el2_dccm_inj_bit_ok(err_inj_bit);
`endif
        el2_dccm_export_bank #(
            .AW (DCCM_AW),
            .DW (DCCM_DATA_WIDTH),
            .EW (DCCM_ECC_WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst_l     (rst_l),
            .clken_i   (dccm.dccm_clken[b]),
            .wren_i    (dccm.dccm_wren_bank[b]),
            .addr_i    (dccm.dccm_addr_bank[b]),
            .wr_data_i (dccm.dccm_wr_data_bank[b]),
            .wr_ecc_i  (dccm.dccm_wr_ecc_bank[b]),
            .dout_o    (bank_dout[b]),
            .ecc_o     (bank_ecc[b])
`ifdef EL2_DCCM_ERR_INJ_EN
            ,
            .inj_arm_i (inj_arm[b]),
            .inj_bit_i (err_inj_bit),
            .inj_dbl_i (err_inj_double),
            .pending_o (err_inj_pending[b])
`endif
        );
    end

    assign dccm.dccm_bank_dout = bank_dout;
    assign dccm.dccm_bank_ecc  = bank_ecc;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_l) begin
            assert (!$isunknown(dccm.dccm_clken))
                else $error("el2_dccm_export_sram: dccm_clken is X/Z");
        end
    end
`endif

endmodule

// File: tb/tb_el2_dccm_export_sram.sv
// tb/tb_el2_dccm_export_sram.sv - self-checking bench for el2_dccm_export_sram
module tb_el2_dccm_export_sram;
    import el2_dccm_export_sram_pkg::*;

    localparam int NB    = DCCM_NUM_BANKS;
    localparam int AW    = DCCM_AW;
    localparam int DW    = DCCM_DATA_WIDTH;
    localparam int EW    = DCCM_ECC_WIDTH;
    localparam int FW    = DW + EW;
    localparam int DEPTH = 1 << AW;
`ifdef EL2_DCCM_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    el2_dccm_export_sram_if dif ();

`ifdef EL2_DCCM_ERR_INJ_EN
    logic            err_inj_valid;
    logic [1:0]      err_inj_bank;
    logic [5:0]      err_inj_bit;
    logic            err_inj_double;
    logic [NB-1:0]   err_inj_pending;
`endif

    el2_dccm_export_sram dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .dccm            (dif)
`ifdef EL2_DCCM_ERR_INJ_EN
        ,
        .err_inj_valid   (err_inj_valid),
        .err_inj_bank    (err_inj_bank),
        .err_inj_bit     (err_inj_bit),
        .err_inj_double  (err_inj_double),
        .err_inj_pending (err_inj_pending)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory keyed by bank*DEPTH+addr, per-bank expected output and pending request.
    logic [FW-1:0] mdl_mem [int];
    logic [FW-1:0] mdl_out [NB];
    bit            mdl_known [NB];
    bit            mdl_pend [NB];
    int            mdl_bit [NB];
    bit            mdl_dbl [NB];

    // Stimulus for the next edge.
    logic [NB-1:0] s_clken;
    logic [NB-1:0] s_wren;
    int            s_addr [NB];
    logic [FW-1:0] s_word [NB];
    bit            s_arm;
    int            s_arm_bank;
    int            s_arm_bit;
    bit            s_arm_dbl;

    task automatic clear_stim();
        s_clken = '0;
        s_wren  = '0;
        s_arm   = 1'b0;
        for (int b = 0; b < NB; b++) begin
            s_addr[b] = 0;
            s_word[b] = '0;
        end
    endtask

    task automatic set_wr(input int b, input int a, input logic [FW-1:0] w);
        s_clken[b] = 1'b1; s_wren[b] = 1'b1; s_addr[b] = a; s_word[b] = w;
    endtask

    task automatic set_rd(input int b, input int a);
        s_clken[b] = 1'b1; s_wren[b] = 1'b0; s_addr[b] = a;
    endtask

    task automatic check_outputs(input string tag);
        for (int b = 0; b < NB; b++) begin
            if (mdl_known[b]) begin
                check_eq($sformatf("%s_b%0d_dout", tag, b), 64'(dif.dccm_bank_dout[b]), 64'(mdl_out[b][DW-1:0]));
                check_eq($sformatf("%s_b%0d_ecc", tag, b), 64'(dif.dccm_bank_ecc[b]), 64'(mdl_out[b][FW-1:DW]));
            end
`ifdef EL2_DCCM_ERR_INJ_EN
            check_eq($sformatf("%s_b%0d_pend", tag, b), 64'(err_inj_pending[b]), 64'(mdl_pend[b]));
`endif
        end
    endtask

    // Drive stimulus, take one edge, advance the model, compare, then return stimulus to idle.
    task automatic clock_edge(input string tag);
        logic [FW-1:0] w;
        int            key;
        bit            arm_ok;
        dif.dccm_clken     = s_clken;
        dif.dccm_wren_bank = s_wren;
        for (int b = 0; b < NB; b++) begin
            dif.dccm_addr_bank[b]    = s_addr[b][AW-1:0];
            dif.dccm_wr_data_bank[b] = s_word[b][DW-1:0];
            dif.dccm_wr_ecc_bank[b]  = s_word[b][FW-1:DW];
        end
`ifdef EL2_DCCM_ERR_INJ_EN
        err_inj_valid  = s_arm;
        err_inj_bank   = 2'(s_arm_bank);
        err_inj_bit    = 6'(s_arm_bit);
        err_inj_double = s_arm_dbl;
`endif
        @(posedge clk);
        #1;
        arm_ok = INJ && s_arm && (s_arm_bit < FW);
        for (int b = 0; b < NB; b++) begin
            if (s_clken[b]) begin
                key = b * DEPTH + s_addr[b];
                if (s_wren[b]) begin
                    mdl_mem[key] = s_word[b];
                end else begin
                    if (mdl_mem.exists(key)) begin
                        w = mdl_mem[key];
                        mdl_known[b] = 1'b1;
                    end else begin
                        w = '0;
                        mdl_known[b] = 1'b0;
                    end
                    if (mdl_pend[b] && !(arm_ok && s_arm_bank == b)) begin
                        w[mdl_bit[b]] = ~w[mdl_bit[b]];
                        if (mdl_dbl[b]) w[(mdl_bit[b] + 1) % FW] = ~w[(mdl_bit[b] + 1) % FW];
                        mdl_pend[b] = 1'b0;
                    end
                    mdl_out[b] = w;
                end
            end
        end
        if (arm_ok) begin
            mdl_pend[s_arm_bank] = 1'b1;
            mdl_bit[s_arm_bank]  = s_arm_bit;
            mdl_dbl[s_arm_bank]  = s_arm_dbl;
        end
        check_outputs(tag);
        clear_stim();
    endtask

    task automatic arm(input int b, input int bi, input bit dbl);
        s_arm = 1'b1; s_arm_bank = b; s_arm_bit = bi; s_arm_dbl = dbl;
    endtask

    int pool [6];

    initial begin
        pool = '{0, 1, 2, 3, DEPTH-2, DEPTH-1};
        s_arm_bank = 0; s_arm_bit = 0; s_arm_dbl = 1'b0;
        clear_stim();
        for (int b = 0; b < NB; b++) begin
            mdl_out[b] = '0; mdl_known[b] = 1'b1; mdl_pend[b] = 1'b0;
            mdl_bit[b] = 0;  mdl_dbl[b] = 1'b0;
        end
        dif.dccm_clken = '0; dif.dccm_wren_bank = '0; dif.dccm_addr_bank = '0;
        dif.dccm_wr_data_bank = '0; dif.dccm_wr_ecc_bank = '0;
`ifdef EL2_DCCM_ERR_INJ_EN
        err_inj_valid = 1'b0; err_inj_bank = '0; err_inj_bit = '0; err_inj_double = 1'b0;
`endif
        rst_l = 1'b0;
        #22;
        check_outputs("reset");
        @(negedge clk);
        rst_l = 1'b1;

        // Basic write then read, checked against literal values too.
        set_wr(0, 5, {7'h2A, 32'hDEADBEEF}); clock_edge("t1_wr");
        set_rd(0, 5);                        clock_edge("t1_rd");
        check_eq("t1_dout_lit", 64'(dif.dccm_bank_dout[0]), 64'h0000_0000_DEAD_BEEF);
        check_eq("t1_ecc_lit",  64'(dif.dccm_bank_ecc[0]),  64'h2A);

        // Hold across idle cycles and a write.
        set_wr(1, 3, {7'h11, 32'h1234_5678}); clock_edge("t2_wr");
        set_rd(1, 3);                         clock_edge("t2_rd");
        for (int i = 0; i < 3; i++) clock_edge("t2_idle");
        set_wr(1, 4, {7'h55, 32'hCAFE_F00D}); clock_edge("t2_wr4");
        check_eq("t2_hold_lit", 64'(dif.dccm_bank_dout[1]), 64'h1234_5678);

        // All banks read different addresses on the same edge.
        for (int b = 0; b < NB; b++) set_wr(b, 10 + b, FW'(64'hA0A0_0000 + b * 64'h0101_0101 + (64'(b) << 32)));
        clock_edge("t3_wr");
        for (int b = 0; b < NB; b++) set_rd(b, 10 + b);
        clock_edge("t3_rd");

        // Address extremes.
        set_wr(2, 0, {7'h01, 32'h0000_0001});         clock_edge("t4_wr0");
        set_wr(2, DEPTH-1, {7'h7E, 32'hFFFF_FFFE});   clock_edge("t4_wrtop");
        set_rd(2, 0);                                 clock_edge("t4_rd0");
        set_rd(2, DEPTH-1);                           clock_edge("t4_rdtop");
        check_eq("t4_top_lit", 64'(dif.dccm_bank_dout[2]), 64'hFFFF_FFFE);

        // Reset mid-run: outputs clear at once, array retained.
        set_rd(0, 5); clock_edge("t5_rd");
        rst_l = 1'b0;
        #1;
        for (int b = 0; b < NB; b++) begin
            mdl_out[b] = '0; mdl_known[b] = 1'b1; mdl_pend[b] = 1'b0;
        end
        check_outputs("t5_rst");
        @(negedge clk);
        rst_l = 1'b1;
        set_rd(0, 5); clock_edge("t5_rdback");
        check_eq("t5_rdback_lit", 64'(dif.dccm_bank_dout[0]), 64'h0000_0000_DEAD_BEEF);

`ifdef EL2_DCCM_ERR_INJ_EN
        // Single-bit injection, one-shot, storage untouched.
        set_wr(3, 9, '0); clock_edge("e1_wr");
        arm(3, 0, 1'b0);  clock_edge("e1_arm");
        set_rd(3, 9);     clock_edge("e1_rd");
        check_eq("e1_dout_lit", 64'(dif.dccm_bank_dout[3]), 64'h1);
        check_eq("e1_pend_lit", 64'(err_inj_pending[3]), 64'h0);
        set_rd(3, 9);     clock_edge("e1_reread");
        check_eq("e1_reread_lit", 64'(dif.dccm_bank_dout[3]), 64'h0);
        // Double fault wrapping from the top bit.
        arm(3, 38, 1'b1); clock_edge("e2_arm");
        set_rd(3, 9);     clock_edge("e2_rd");
        check_eq("e2_dout_lit", 64'(dif.dccm_bank_dout[3]), 64'h1);
        check_eq("e2_ecc_lit",  64'(dif.dccm_bank_ecc[3]),  64'h40);
        // Out-of-range bit arms nothing; same-edge arm and read is clean.
        arm(1, 39, 1'b0); clock_edge("e3_oor");
        arm(3, 5, 1'b0); set_rd(3, 9); clock_edge("e4_same");
        set_rd(3, 9);    clock_edge("e4_next");
`endif

        // Randomized phase over a small address pool so reads mostly hit written words.
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 6; i++) begin
                set_wr(b, pool[i], {$urandom, $urandom}[FW-1:0]);
                clock_edge("rnd_fill");
            end
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NB; b++) begin
                s_clken[b] = ($urandom_range(0, 3) != 0);
                s_wren[b]  = ($urandom_range(0, 2) == 0);
                s_addr[b]  = pool[$urandom_range(0, 5)];
                s_word[b]  = {$urandom, $urandom}[FW-1:0];
            end
            if (INJ && $urandom_range(0, 7) == 0) arm($urandom_range(0, NB-1), $urandom_range(0, 45), 1'($urandom_range(0, 1)));
            clock_edge("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
